// File: rtl/idma_desc64_reg_submitter.sv
// Register-bus initiator that feeds buffered 64-bit descriptor addresses
// into the desc64 frontend DESC_ADDR register, one write per address.

package idma_desc64_reg_submitter_pkg;
    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [63:0] wdata;
        logic [7:0]  wstrb;
        logic        valid;
    } reg_req_t;

    typedef struct packed {
        logic [63:0] rdata;
        logic        error;
        logic        ready;
    } reg_rsp_t;
endpackage

// state | meaning
// IDLE  | no request on the bus; wait for a buffered address and en_i
// REQ   | write of the FIFO head held on the bus until the frontend accepts it
module idma_desc64_reg_submitter #(
    parameter int unsigned FifoDepth       = 4,
    parameter int unsigned TimeoutCycles   = 1024,
    parameter logic [31:0] DescAddrRegAddr = 32'h0000_0000,
    parameter type         reg_req_t       = idma_desc64_reg_submitter_pkg::reg_req_t,
    parameter type         reg_rsp_t       = idma_desc64_reg_submitter_pkg::reg_rsp_t
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        en_i,
    input  logic [63:0] desc_addr_i,
    input  logic        desc_valid_i,
    output logic        desc_ready_o,
    output reg_req_t    reg_req_o,
    input  reg_rsp_t    reg_rsp_i,
    output logic [31:0] submitted_cnt_o,
    output logic        err_o,
    output logic [63:0] err_addr_o,
    output logic        err_sticky_o,
    output logic        timeout_o,
    input  logic        clear_i
);
    localparam int unsigned PtrW   = (FifoDepth > 2) ? $clog2(FifoDepth) : 1;
    localparam int unsigned CntW   = PtrW + 1;
    localparam int unsigned StallW = $clog2(TimeoutCycles + 1);

    typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_e;

    state_e            state_q, state_d;
    logic [63:0]       mem_q [FifoDepth];
    logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]   count_q, count_d;
    logic [StallW-1:0] stall_cnt_q;
    logic              full, empty, push, pop, done, stalled;
    logic              timeout_rise, timeout_sat;
    logic [63:0]       head;
    logic              unused_rdata;

    assign unused_rdata = ^reg_rsp_i.rdata;

    assign full         = (count_q == CntW'(FifoDepth));
    assign empty        = (count_q == '0);
    assign desc_ready_o = !full;
    assign push         = desc_valid_i && !full;
    assign head         = mem_q[rd_ptr_q];
    assign done         = (state_q == REQ) && reg_rsp_i.ready;
    assign stalled      = (state_q == REQ) && !reg_rsp_i.ready;
    assign pop          = done;
    assign count_d      = count_q + CntW'(push) - CntW'(pop);

    // The rising edge of the stall count is a fresh event; the saturated
    // level re-arms the flag one cycle after a clear while still stalled.
    assign timeout_rise = stalled && (stall_cnt_q == StallW'(TimeoutCycles - 1));
    assign timeout_sat  = (state_q == REQ) && (stall_cnt_q == StallW'(TimeoutCycles));

    // FIFO storage; contents are don't-care until pointed at by count
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= desc_addr_i;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= (wr_ptr_q == PtrW'(FifoDepth - 1)) ? '0 : wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= (rd_ptr_q == PtrW'(FifoDepth - 1)) ? '0 : rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    // FSM state register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next state and bus request; a started request is never withdrawn
    always_comb begin
        state_d   = state_q;
        reg_req_o = '0;
        unique case (state_q)
            IDLE: begin
                if (!empty && en_i) state_d = REQ;
            end
            REQ: begin
                reg_req_o.valid = 1'b1;
                reg_req_o.write = 1'b1;
                reg_req_o.addr  = DescAddrRegAddr;
                reg_req_o.wdata = head;
                reg_req_o.wstrb = 8'hFF;
                if (done && !(en_i && (count_d != '0))) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Completion bookkeeping: success count, error capture and sticky flag
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            submitted_cnt_o <= '0;
            err_o           <= 1'b0;
            err_addr_o      <= '0;
            err_sticky_o    <= 1'b0;
        end else begin
            err_o <= done && reg_rsp_i.error;
            if (done && !reg_rsp_i.error) submitted_cnt_o <= submitted_cnt_o + 32'd1;
            if (done && reg_rsp_i.error) begin
                err_addr_o   <= head;
                err_sticky_o <= 1'b1;
            end else if (clear_i) begin
                err_sticky_o <= 1'b0;
            end
        end
    end

    // Stall counter saturating at TimeoutCycles, and the sticky timeout flag
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt_q <= '0;
            timeout_o   <= 1'b0;
        end else begin
            if (stalled) begin
                if (stall_cnt_q != StallW'(TimeoutCycles)) stall_cnt_q <= stall_cnt_q + 1'b1;
            end else begin
                stall_cnt_q <= '0;
            end
            if (clear_i) timeout_o <= timeout_rise;
            else         timeout_o <= timeout_o || timeout_rise || timeout_sat;
        end
    end
endmodule
